// File: rtl/axi_stream_pkt_arbiter.sv
// Packet-locked round-robin arbiter in front of a shared AXI-Stream datapath.
// A grant is taken in IDLE and held until the tlast beat handshakes, so packets
// from different inputs never interleave downstream.
module axi_stream_pkt_arbiter #(
    parameter int unsigned NumInputs = 4,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned UserWidth = 1,
    parameter int unsigned CntWidth  = 16,
    localparam int unsigned SelWidth = $clog2(NumInputs)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumInputs-1:0]           in_tvalid_i,
    output logic [NumInputs-1:0]           in_tready_o,
    input  logic [NumInputs*DataWidth-1:0] in_tdata_i,
    input  logic [NumInputs-1:0]           in_tlast_i,
    input  logic [NumInputs*UserWidth-1:0] in_tuser_i,
    output logic                           out_tvalid_o,
    input  logic                           out_tready_i,
    output logic [DataWidth-1:0]           out_tdata_o,
    output logic                           out_tlast_o,
    output logic [UserWidth-1:0]           out_tuser_o,
    output logic [SelWidth-1:0]            sel_o,
    output logic                           busy_o,
    output logic [CntWidth-1:0]            pkt_cnt_o
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q, state_d;
    logic [SelWidth-1:0]   grant_q, grant_d;
    logic [SelWidth-1:0]   last_q, last_d;
    logic [CntWidth-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic [SelWidth-1:0]   pick;
    logic [SelWidth-1:0]   idx;
    logic                  found;
    logic                  sel_valid;
    logic                  sel_last;
    logic [DataWidth-1:0]  sel_data;
    logic [UserWidth-1:0]  sel_user;

    // Round-robin search starting just after the last granted input.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned off = 1; off <= NumInputs; off++) begin
            idx = SelWidth'((32'(last_q) + off) % NumInputs);
            if (!found && in_tvalid_i[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Select the granted input's beat.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_user  = '0;
        for (int unsigned k = 0; k < NumInputs; k++) begin
            if (grant_q == SelWidth'(k)) begin
                sel_valid = in_tvalid_i[k];
                sel_last  = in_tlast_i[k];
                sel_data  = in_tdata_i[k*DataWidth +: DataWidth];
                sel_user  = in_tuser_i[k*UserWidth +: UserWidth];
            end
        end
    end

    // Next-state: grant in IDLE, release on the tlast handshake.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        pkt_cnt_d = pkt_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|in_tvalid_i) begin
                    grant_d = pick;
                    last_d  = pick;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (sel_valid && out_tready_i && sel_last) begin
                    state_d   = StIdle;
                    pkt_cnt_d = pkt_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; reset forces the handshake signals low even before the first edge.
    always_comb begin
        out_tvalid_o = 1'b0;
        in_tready_o  = '0;
        out_tdata_o  = sel_data;
        out_tlast_o  = sel_last;
        out_tuser_o  = sel_user;
        busy_o       = 1'b0;
        sel_o        = '0;
        pkt_cnt_o    = rst_i ? '0 : pkt_cnt_q;
        if (!rst_i && state_q == StLocked) begin
            out_tvalid_o         = sel_valid;
            in_tready_o[grant_q] = out_tready_i;
            busy_o               = 1'b1;
            sel_o                = grant_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= SelWidth'(NumInputs - 1);
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_axi_stream_pkt_arbiter.sv
// Randomized bench for axi_stream_pkt_arbiter: per-input packet queues act as
// AXI-Stream masters and a rule-level model predicts grants, bubbles and counts.
module tb_axi_stream_pkt_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int UW = 1;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    in_tvalid_i = '0;
    logic [N-1:0]    in_tready_o;
    logic [N*DW-1:0] in_tdata_i = '0;
    logic [N-1:0]    in_tlast_i = '0;
    logic [N*UW-1:0] in_tuser_i = '0;
    logic            out_tvalid_o;
    logic            out_tready_i = 1'b0;
    logic [DW-1:0]   out_tdata_o;
    logic            out_tlast_o;
    logic [UW-1:0]   out_tuser_o;
    logic [1:0]      sel_o;
    logic            busy_o;
    logic [CW-1:0]   pkt_cnt_o;

    axi_stream_pkt_arbiter #(
        .NumInputs(N), .DataWidth(DW), .UserWidth(UW), .CntWidth(CW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .in_tvalid_i  (in_tvalid_i),
        .in_tready_o  (in_tready_o),
        .in_tdata_i   (in_tdata_i),
        .in_tlast_i   (in_tlast_i),
        .in_tuser_i   (in_tuser_i),
        .out_tvalid_o (out_tvalid_o),
        .out_tready_i (out_tready_i),
        .out_tdata_o  (out_tdata_o),
        .out_tlast_o  (out_tlast_o),
        .out_tuser_o  (out_tuser_o),
        .sel_o        (sel_o),
        .busy_o       (busy_o),
        .pkt_cnt_o    (pkt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Source state and reference model.
    beat_t         q [N][$];
    logic [N-1:0]  vld = '0;
    logic [DW-1:0] log_q [$];
    int            valid_pct = 100;
    int            ready_pct = 100;
    bit            auto_gen  = 1'b0;
    bit            exp_busy  = 1'b0;
    int            exp_sel   = 0;
    int            m_last    = N - 1;
    logic [CW-1:0] m_cnt     = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_beat(input int k, input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        b.u = UW'($urandom);
        q[k].push_back(b);
    endtask

    task automatic push_pkt(input int k, input int len);
        for (int i = 0; i < len; i++)
            push_beat(k, {8'(k), 24'($urandom)}, (i == len - 1));
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += q[k].size();
        return s + int'(exp_busy);
    endfunction

    // Present source beats; a raised tvalid is held until its handshake.
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (auto_gen && q[k].size() == 0 && $urandom_range(99) < 15)
                push_pkt(k, $urandom_range(1, 4));
            if (!vld[k] && q[k].size() > 0 && $urandom_range(99) < valid_pct)
                vld[k] = 1'b1;
            if (q[k].size() > 0) begin
                in_tdata_i[k*DW +: DW] = q[k][0].d;
                in_tlast_i[k]          = q[k][0].l;
                in_tuser_i[k*UW +: UW] = q[k][0].u;
            end else begin
                in_tdata_i[k*DW +: DW] = $urandom;
                in_tlast_i[k]          = 1'($urandom);
                in_tuser_i[k*UW +: UW] = UW'($urandom);
            end
        end
        in_tvalid_i  = vld;
        out_tready_i = ($urandom_range(99) < ready_pct);
    endtask

    task automatic check_cycle();
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (rst_i) begin
            check_eq("rst_tvalid", out_tvalid_o, 0);
            check_eq("rst_tready", in_tready_o, 0);
            check_eq("rst_busy", busy_o, 0);
            check_eq("rst_sel", sel_o, 0);
            check_eq("rst_cnt", pkt_cnt_o, 0);
        end else begin
            check_eq("busy", busy_o, exp_busy);
            check_eq("pkt_cnt", pkt_cnt_o, m_cnt);
            if (exp_busy) begin
                exp_rdy[exp_sel] = out_tready_i;
                check_eq("sel", sel_o, exp_sel);
                check_eq("out_tvalid", out_tvalid_o, vld[exp_sel]);
                check_eq("in_tready", in_tready_o, exp_rdy);
                if (vld[exp_sel]) begin
                    check_eq("out_tdata", out_tdata_o, q[exp_sel][0].d);
                    check_eq("out_tlast", out_tlast_o, q[exp_sel][0].l);
                    check_eq("out_tuser", out_tuser_o, q[exp_sel][0].u);
                end
            end else begin
                check_eq("idle_tvalid", out_tvalid_o, 0);
                check_eq("idle_tready", in_tready_o, exp_rdy);
            end
        end
    endtask

    // One clock cycle: drive, check at negedge, advance the model, retire the beat.
    task automatic step();
        int hs;
        hs = -1;
        drive();
        @(negedge clk_i);
        check_cycle();
        if (rst_i) begin
            exp_busy = 1'b0;
            m_last   = N - 1;
            m_cnt    = '0;
        end else if (!exp_busy) begin
            if (|vld) begin
                for (int off = 1; off <= N; off++) begin
                    int c;
                    c = (m_last + off) % N;
                    if (!exp_busy && vld[c]) begin
                        exp_busy = 1'b1;
                        exp_sel  = c;
                    end
                end
                m_last = exp_sel;
            end
        end else if (vld[exp_sel] && out_tready_i) begin
            hs = exp_sel;
            if (q[exp_sel][0].l) begin
                exp_busy = 1'b0;
                m_cnt    = m_cnt + 1'b1;
            end
        end
        @(posedge clk_i);
        #1;
        if (hs >= 0) begin
            log_q.push_back(q[hs][0].d);
            void'(q[hs].pop_front());
            vld[hs] = 1'b0;
        end
    endtask

    task automatic drain(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (pending() > 0 && n < max_cycles) begin
            step();
            n++;
        end
        check_eq(tag, pending(), 0);
    endtask

    initial begin
        logic [CW-1:0] cnt0;

        // Reset held with every input requesting single-beat packets tagged by index.
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) push_beat(k, DW'(k), 1'b1);
        rst_i = 1'b1;
        repeat (3) step();
        rst_i = 1'b0;
        log_q.delete();
        drain("rr_drain", 100);
        for (int i = 0; i < 6; i++) check_eq("rr_order", log_q[i], DW'(i % N));

        // Input 2 alone, two-beat packet.
        log_q.delete();
        cnt0 = pkt_cnt_o;
        push_beat(2, 32'h1234_56ef, 1'b0);
        push_beat(2, 32'haabb_ccdd, 1'b1);
        drain("p2_drain", 50);
        check_eq("p2_beat0", log_q[0], 32'h1234_56ef);
        check_eq("p2_beat1", log_q[1], 32'haabb_ccdd);
        check_eq("p2_cnt", pkt_cnt_o, cnt0 + 1'b1);
        check_eq("p2_busy", busy_o, 0);

        // Input 0 locked, then inputs 1 and 3 request and are held off.
        log_q.delete();
        push_pkt(0, 5);
        repeat (3) step();
        push_pkt(1, 1);
        push_pkt(3, 1);
        drain("hold_drain", 50);
        for (int i = 0; i < 7; i++)
            check_eq("hold_order", log_q[i][31:24], (i < 5) ? 0 : ((i == 5) ? 1 : 3));

        // Output backpressure mid-packet.
        log_q.delete();
        cnt0 = pkt_cnt_o;
        push_pkt(1, 4);
        repeat (3) step();
        ready_pct = 0;
        repeat (3) step();
        ready_pct = 100;
        drain("bp_drain", 50);
        check_eq("bp_beats", log_q.size(), 4);
        check_eq("bp_cnt", pkt_cnt_o, cnt0 + 1'b1);

        // Reset while input 1 is mid-packet.
        log_q.delete();
        push_pkt(1, 4);
        repeat (3) step();
        check_eq("mid_busy", busy_o, 1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        check_eq("rst_drop", busy_o, 0);
        drain("rst_drain", 50);
        check_eq("rst_beats", log_q.size(), 4);
        check_eq("rst_cnt_restart", pkt_cnt_o, 1);

        // Random traffic with random gaps and backpressure.
        valid_pct = 60;
        ready_pct = 70;
        auto_gen  = 1'b1;
        repeat (4000) step();
        auto_gen  = 1'b0;
        ready_pct = 100;
        drain("rand_drain", 500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
